morse_decoder: RTL

Receive-side counterpart of the Morse transmitter: samples a single on/off light/key line once per `half_sec` edge, classifies marks as dot or dash, and recognises the inter-letter gap. It decodes each completed letter to the 3-bit letter code A–H (0–7) used by the transmitter's letter select. Sits at the board boundary (GPIO or switch input) and feeds LEDs/HEX display; looping the transmitter's `light` output into it must reproduce the transmitted `letter_in`.

---
 rtl/morse_pkg.sv | 80 ++++++++
 rtl/morse_symbol_lut.sv | 32 +++
 rtl/morse_decoder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// morse_pkg: shared definitions for the Morse transmitter and receiver.
//   - letter codes A..H (0..7) used by the transmitter letter select
//   - decoder FSM state encodings
//   - DOT/DASH symbol bit values
//   - code table: symbol count and symbol pattern per letter.
//     In the pattern, the first symbol is in bit 0 and dash = 1.
//     Bits above the length are zero.
package morse_pkg;

   typedef enum logic [2:0] {
      LTR_A = 3'd0,
      LTR_B = 3'd1,
      LTR_C = 3'd2,
      LTR_D = 3'd3,
      LTR_E = 3'd4,
      LTR_F = 3'd5,
      LTR_G = 3'd6,
      LTR_H = 3'd7
   } letter_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MARK  = 2'd1,
      ST_SPACE = 2'd2
   } state_t;

   localparam logic DOT  = 1'b0;
   localparam logic DASH = 1'b1;

   localparam logic [2:0] MAX_SYMBOLS = 3'd4;

   // Number of symbols in each letter.
   function automatic logic [2:0] code_len(input letter_t ltr);
      logic [2:0] len;
      case (ltr)
         LTR_A:   len = 3'd2;
         LTR_B:   len = 3'd4;
         LTR_C:   len = 3'd4;
         LTR_D:   len = 3'd3;
         LTR_E:   len = 3'd1;
         LTR_F:   len = 3'd4;
         LTR_G:   len = 3'd3;
         LTR_H:   len = 3'd4;
         default: len = 3'd0;
      endcase
      return len;
   endfunction

   // Symbol pattern of each letter. The first symbol is in bit 0.
   function automatic logic [3:0] code_pattern(input letter_t ltr);
      logic [3:0] pat;
      case (ltr)
         LTR_A:   pat = 4'b0010;  // .-
         LTR_B:   pat = 4'b0001;  // -...
         LTR_C:   pat = 4'b0101;  // -.-.
         LTR_D:   pat = 4'b0001;  // -..
         LTR_E:   pat = 4'b0000;  // .
         LTR_F:   pat = 4'b0100;  // ..-.
         LTR_G:   pat = 4'b0011;  // --.
         LTR_H:   pat = 4'b0000;  // ....
         default: pat = 4'b0000;
      endcase
      return pat;
   endfunction

   // Mask that keeps the lowest `count` symbol bits.
   function automatic logic [3:0] len_mask(input logic [2:0] count);
      logic [3:0] m;
      case (count)
         3'd0:    m = 4'b0000;
         3'd1:    m = 4'b0001;
         3'd2:    m = 4'b0011;
         3'd3:    m = 4'b0111;
         3'd4:    m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/morse_symbol_lut.sv
// morse_symbol_lut: combinational lookup from collected symbols to a letter.
// Ports:
//   symbol_count  in   3  number of symbols collected (0..4)
//   symbol_bits   in   4  symbols, dash = 1, first symbol in bit 0
//   match         out  1  the pattern is one of the letters A..H
//   letter        out  3  code of the matching letter (0 when no match)
module morse_symbol_lut
   import morse_pkg::*;
(
   input  logic [2:0] symbol_count,
   input  logic [3:0] symbol_bits,
   output logic       match,
   output logic [2:0] letter
);

   // Scan the code table for an entry of equal length and pattern.
   always_comb begin
      match  = 1'b0;
      letter = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (!match
             && symbol_count == code_len(letter_t'(3'(i)))
             && (symbol_bits & len_mask(symbol_count)) == code_pattern(letter_t'(3'(i)))) begin
            match  = 1'b1;
            letter = 3'(i);
         end else begin
            match  = match;
         end
      end
   end

endmodule

// File: rtl/morse_decoder.sv
// morse_decoder: receives an on/off Morse line and decodes letters A..H.
// One sample is taken per rising edge of half_sec, which is one Morse time unit.
// Parameters:
//   DASH_MIN    a mark run this long or longer is a dash; a shorter run is a dot
//   MARK_MAX    marks longer than this make the letter illegal
//   LETTER_GAP  this many consecutive space samples end a letter
// Ports:
//   half_sec      in   1  sample clock
//   reset         in   1  synchronous, active-high
//   light_in      in   1  sampled line, 1 = mark
//   letter_out    out  3  last successfully decoded letter code
//   letter_valid  out  1  one-cycle pulse: letter_out was just updated
//   decode_error  out  1  one-cycle pulse: a letter ended but was illegal
//   symbol_bits   out  4  symbols collected so far, dash = 1, first in bit 0
//   symbol_count  out  3  number of symbols collected (0..4)
//   state         out  2  FSM state (IDLE/MARK/SPACE)
module morse_decoder
   import morse_pkg::*;
#(
   parameter int unsigned DASH_MIN   = 2,
   parameter int unsigned MARK_MAX   = 4,
   parameter int unsigned LETTER_GAP = 3
) (
   input  logic       half_sec,
   input  logic       reset,
   input  logic       light_in,
   output logic [2:0] letter_out,
   output logic       letter_valid,
   output logic       decode_error,
   output logic [3:0] symbol_bits,
   output logic [2:0] symbol_count,
   output logic [1:0] state
);

   localparam logic [2:0] DASH_MIN_C   = 3'(DASH_MIN);
   localparam logic [2:0] MARK_MAX_C   = 3'(MARK_MAX);
   localparam logic [2:0] LETTER_GAP_C = 3'(LETTER_GAP);

   state_t     state_r,        state_nxt;
   logic [2:0] high_cnt_r,     high_cnt_nxt;
   logic [2:0] low_cnt_r,      low_cnt_nxt;
   logic [3:0] symbol_bits_r,  symbol_bits_nxt;
   logic [2:0] symbol_count_r, symbol_count_nxt;
   logic       err_r,          err_nxt;
   logic [2:0] letter_r,       letter_nxt;
   logic       valid_r,        valid_nxt;
   logic       derr_r,         derr_nxt;

   logic       lut_match;
   logic [2:0] lut_letter;
   logic       sym;
   logic [2:0] low_inc;

   morse_symbol_lut u_lut (
      .symbol_count (symbol_count_r),
      .symbol_bits  (symbol_bits_r),
      .match        (lut_match),
      .letter       (lut_letter)
   );

   // Register the FSM state, run counters, symbol store and outputs.
   always_ff @(posedge half_sec) begin
      if (reset) begin
         state_r        <= ST_IDLE;
         high_cnt_r     <= 3'd0;
         low_cnt_r      <= 3'd0;
         symbol_bits_r  <= 4'd0;
         symbol_count_r <= 3'd0;
         err_r          <= 1'b0;
         letter_r       <= 3'd0;
         valid_r        <= 1'b0;
         derr_r         <= 1'b0;
      end else begin
         state_r        <= state_nxt;
         high_cnt_r     <= high_cnt_nxt;
         low_cnt_r      <= low_cnt_nxt;
         symbol_bits_r  <= symbol_bits_nxt;
         symbol_count_r <= symbol_count_nxt;
         err_r          <= err_nxt;
         letter_r       <= letter_nxt;
         valid_r        <= valid_nxt;
         derr_r         <= derr_nxt;
      end
   end

   // Next-state logic: classify mark runs, collect symbols, detect the letter gap.
   always_comb begin
      state_nxt        = state_r;
      high_cnt_nxt     = high_cnt_r;
      low_cnt_nxt      = low_cnt_r;
      symbol_bits_nxt  = symbol_bits_r;
      symbol_count_nxt = symbol_count_r;
      err_nxt          = err_r;
      letter_nxt       = letter_r;
      valid_nxt        = 1'b0;
      derr_nxt         = 1'b0;
      sym              = (high_cnt_r >= DASH_MIN_C) ? DASH : DOT;
      low_inc          = low_cnt_r + 3'd1;

      case (state_r)
         ST_IDLE: begin
            if (light_in) begin
               state_nxt    = ST_MARK;
               high_cnt_nxt = 3'd1;
            end else begin
               state_nxt = ST_IDLE;
            end
         end

         ST_MARK: begin
            if (light_in) begin
               if (high_cnt_r != 3'd7) begin
                  high_cnt_nxt = high_cnt_r + 3'd1;
               end else begin
                  high_cnt_nxt = 3'd7;
               end
            end else begin
               if (high_cnt_r > MARK_MAX_C) begin
                  err_nxt = 1'b1;
               end else begin
                  err_nxt = err_r;
               end
               // A fifth symbol cannot be stored; it only marks the letter illegal.
               if (symbol_count_r < MAX_SYMBOLS) begin
                  symbol_bits_nxt[symbol_count_r[1:0]] = sym;
                  symbol_count_nxt = symbol_count_r + 3'd1;
               end else begin
                  err_nxt = 1'b1;
               end
               low_cnt_nxt = 3'd1;
               state_nxt   = ST_SPACE;
            end
         end

         ST_SPACE: begin
            if (light_in) begin
               // A mark before the gap completes continues the same letter.
               state_nxt    = ST_MARK;
               high_cnt_nxt = 3'd1;
               low_cnt_nxt  = 3'd0;
            end else if (low_inc == LETTER_GAP_C) begin
               if (!err_r && lut_match) begin
                  letter_nxt = lut_letter;
                  valid_nxt  = 1'b1;
               end else begin
                  derr_nxt = 1'b1;
               end
               state_nxt        = ST_IDLE;
               symbol_bits_nxt  = 4'd0;
               symbol_count_nxt = 3'd0;
               err_nxt          = 1'b0;
               high_cnt_nxt     = 3'd0;
               low_cnt_nxt      = 3'd0;
            end else begin
               low_cnt_nxt = low_inc;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign letter_out   = letter_r;
   assign letter_valid = valid_r;
   assign decode_error = derr_r;
   assign symbol_bits  = symbol_bits_r;
   assign symbol_count = symbol_count_r;
   assign state        = state_r;

endmodule
